mem_sweep: RTL

- Initiator-side controller for the team's single-clock, read-first, 1-cycle-latency BRAM (`raddr`/`waddr`/`din`/`dout`, write every cycle).
- Fills the memory with a deterministic pattern, reads it back, computes a checksum and counts mismatches.
- Sits beside a memory instance in bitstream re-init experiments, so on-chip contents can be checked after a reconfiguration.
- Non-destructive in read/idle states: it writes each word back with its own value, so write-always memories stay intact.

---
 rtl/mem_sweep_pkg.sv | 29 ++
 rtl/mem_sweep_acc.sv | 46 ++++
 rtl/mem_sweep.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_sweep_pkg.sv
// rtl/mem_sweep_pkg.sv - shared types, mode codes and pattern/checksum helpers for mem_sweep
package mem_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SETTLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_READ    = 2'b00;
  localparam logic [1:0] MODE_FILL    = 2'b01;
  localparam logic [1:0] MODE_FILLCHK = 2'b10;

  localparam logic [31:0] NO_ERR_ADDR = 32'hFFFF_FFFF;

  // Fill pattern: the seed (zero-extended) XOR the address; callers truncate to word width.
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] a);
    return seed ^ a;
  endfunction

  // Rotate-left-by-one used by the running checksum.
  function automatic logic [31:0] rotl32(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction

endpackage

// File: rtl/mem_sweep_acc.sv
// rtl/mem_sweep_acc.sv - read-data accumulator: checksum, mismatch count, first error address
module mem_sweep_acc
  import mem_sweep_pkg::*;
#(
  parameter int WID_MEM = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               valid,
  input  logic [31:0]        addr,
  input  logic [WID_MEM-1:0] word,
  input  logic [WID_MEM-1:0] expected,
  input  logic               check_en,
  output logic [31:0]        wb_addr,
  output logic [31:0]        checksum,
  output logic [15:0]        err_count,
  output logic [31:0]        first_err_addr
);

  // Address issued last cycle; it names the word now on the read port, even while in reset,
  // so the write-back never lands a word on the wrong address.
  always_ff @(posedge clk) begin
    wb_addr <= addr;
  end

  // Fold each returned word into the checksum and, when verifying, record mismatches.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      checksum       <= 32'd0;
      err_count      <= 16'd0;
      first_err_addr <= NO_ERR_ADDR;
    end else if (valid) begin
      checksum <= rotl32(checksum) ^ 32'(word);
      if (check_en && (word != expected)) begin
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 16'd1;
        end
        if (first_err_addr == NO_ERR_ADDR) begin
          first_err_addr <= wb_addr;
        end
      end
    end
  end

endmodule

// File: rtl/mem_sweep.sv
// rtl/mem_sweep.sv - BRAM fill / readback / checksum sweep controller
module mem_sweep
  import mem_sweep_pkg::*;
#(
  parameter int WID_MEM   = 16,
  parameter int DEPTH_MEM = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WID_MEM-1:0] seed,
  output logic [31:0]        raddr,
  output logic [31:0]        waddr,
  output logic [WID_MEM-1:0] din,
  output logic               we,
  input  logic [WID_MEM-1:0] dout_mem,
  output logic               busy,
  output logic               done,
  output logic [31:0]        checksum,
  output logic [15:0]        err_count,
  output logic [31:0]        first_err_addr
);

  localparam logic [31:0] LAST_ADDR = 32'(DEPTH_MEM - 1);

  state_t             state;
  logic [1:0]         mode_q;
  logic [WID_MEM-1:0] seed_q;
  logic [WID_MEM-1:0] din_q;
  logic               rd_v;
  logic [31:0]        wb_addr;
  logic [1:0]         mode_eff;
  logic               accept;
  logic [WID_MEM-1:0] expected;

  assign mode_eff = (mode == 2'b11) ? MODE_READ : mode;
  assign accept   = (state == ST_IDLE) && start;
  assign expected = WID_MEM'(pat(32'(seed_q), wb_addr));

  // Writes carry the pattern during FILL/SETTLE; everywhere else the word just read goes
  // back to the address it came from, so a write-every-cycle memory keeps its contents.
  assign waddr = we ? raddr : wb_addr;
  assign din   = we ? din_q : dout_mem;

  // Sweep sequencer: address counter, fill data, and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      raddr  <= 32'd0;
      din_q  <= '0;
      we     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd_v   <= 1'b0;
      mode_q <= MODE_READ;
      seed_q <= '0;
    end else begin
      done <= 1'b0;
      rd_v <= (state == ST_READ);
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q <= mode_eff;
            seed_q <= seed;
            busy   <= 1'b1;
            raddr  <= 32'd0;
            if (mode_eff == MODE_FILL || mode_eff == MODE_FILLCHK) begin
              state <= ST_FILL;
              din_q <= WID_MEM'(pat(32'(seed), 32'd0));
              we    <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_FILL: begin
          if (raddr == LAST_ADDR) begin
            // Repeat the last write once so the first read write-back sees fresh data.
            state <= ST_SETTLE;
          end else begin
            raddr <= raddr + 32'd1;
            din_q <= WID_MEM'(pat(32'(seed_q), raddr + 32'd1));
          end
        end
        ST_SETTLE: begin
          we <= 1'b0;
          if (mode_q == MODE_FILLCHK) begin
            state <= ST_READ;
            raddr <= 32'd0;
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_READ: begin
          if (raddr == LAST_ADDR) begin
            state <= ST_DRAIN;
          end else begin
            raddr <= raddr + 32'd1;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  mem_sweep_acc #(
    .WID_MEM(WID_MEM)
  ) u_acc (
    .clk           (clk),
    .reset         (reset),
    .clr           (accept),
    .valid         (rd_v),
    .addr          (raddr),
    .word          (dout_mem),
    .expected      (expected),
    .check_en      (mode_q == MODE_FILLCHK),
    .wb_addr       (wb_addr),
    .checksum      (checksum),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

endmodule
